// File: rtl/alu_arm_pkg.sv
// Shared types for the pipelined ARM ALU: op codes, NZCV flag struct and flag bit positions.
// ALU_ARM_SHIFT_EN (when defined) enables the shift op codes in alu_arm_core.
package alu_arm_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'd0,
        OP_EOR = 4'd1,
        OP_SUB = 4'd2,
        OP_RSB = 4'd3,
        OP_ADD = 4'd4,
        OP_ADC = 4'd5,
        OP_SBC = 4'd6,
        OP_ORR = 4'd7,
        OP_LSL = 4'd8,
        OP_LSR = 4'd9,
        OP_ASR = 4'd10,
        OP_ROR = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic alu_flags_t makeFlags(input logic n, input logic z,
                                             input logic c, input logic v);
        alu_flags_t f;
        f.n = n;
        f.z = z;
        f.c = c;
        f.v = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_arm_core.sv
// Combinational ARM ALU datapath: WIDTH+1-bit adder, logic ops and (with ALU_ARM_SHIFT_EN) a barrel shifter.
// Without ALU_ARM_SHIFT_EN, op codes 8..11 fall through to the illegal-op path.
module alu_arm_core
    import alu_arm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    input  logic             cin_i,
    input  alu_flags_t       flags_i,
    output logic [WIDTH-1:0] result_o,
    output alu_flags_t       nzcv_o,
    output logic             err_o
);

    alu_op_e          opE;
    logic [WIDTH-1:0] addX;
    logic [WIDTH-1:0] addY;
    logic             addC;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             overflow;
    logic             err;

    assign opE = alu_op_e'(op_i);

`ifdef ALU_ARM_SHIFT_EN
    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [SHW-1:0]   shAmt;
    logic             shZero;
    logic [WIDTH:0]   lslWide;
    logic [WIDTH:0]   lsrWide;
    logic [WIDTH:0]   asrWide;
    logic [WIDTH-1:0] rorRes;

    // The extra bit beside each shifted operand catches the last bit shifted out.
    assign shAmt   = b_i[SHW-1:0];
    assign shZero  = (shAmt == '0);
    assign lslWide = {1'b0, a_i} << shAmt;
    assign lsrWide = {a_i, 1'b0} >> shAmt;
    assign asrWide = $signed({a_i, 1'b0}) >>> shAmt;
    assign rorRes  = (a_i >> shAmt) | (a_i << (WIDTH - int'(shAmt)));
`endif

    // Subtracts are folded into the adder as X + ~Y + carry-in, so C is NOT-borrow.
    always_comb begin
        addX = a_i;
        addY = b_i;
        addC = 1'b0;
        case (opE)
            OP_SUB: begin
                addY = ~b_i;
                addC = 1'b1;
            end
            OP_RSB: begin
                addX = b_i;
                addY = ~a_i;
                addC = 1'b1;
            end
            OP_ADC: begin
                addC = cin_i;
            end
            OP_SBC: begin
                addY = ~b_i;
                addC = cin_i;
            end
            default: begin
            end
        endcase
    end

    assign sum = {1'b0, addX} + {1'b0, addY} + {{WIDTH{1'b0}}, addC};

    always_comb begin
        res      = '0;
        carry    = flags_i.c;
        overflow = flags_i.v;
        err      = 1'b0;
        case (opE)
            OP_AND: res = a_i & b_i;
            OP_EOR: res = a_i ^ b_i;
            OP_ORR: res = a_i | b_i;
            OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC: begin
                res      = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (addX[WIDTH-1] == addY[WIDTH-1]) &&
                           (sum[WIDTH-1] != addX[WIDTH-1]);
            end
`ifdef ALU_ARM_SHIFT_EN
            OP_LSL: begin
                res = lslWide[WIDTH-1:0];
                if (!shZero) carry = lslWide[WIDTH];
            end
            OP_LSR: begin
                res = lsrWide[WIDTH:1];
                if (!shZero) carry = lsrWide[0];
            end
            OP_ASR: begin
                res = asrWide[WIDTH:1];
                if (!shZero) carry = asrWide[0];
            end
            OP_ROR: begin
                res = rorRes;
                if (!shZero) carry = rorRes[WIDTH-1];
            end
`endif
            default: begin
                err = 1'b1;
            end
        endcase
    end

    assign result_o = res;
    assign err_o    = err;
    assign nzcv_o   = err ? flags_i
                          : makeFlags(res[WIDTH-1], (res == '0), carry, overflow);

endmodule

// File: rtl/alu_arm_pipe.sv
// Registered ARM ALU execute stage: valid/ready handshake, one output register and the architectural NZCV register.
// Build with ALU_ARM_SHIFT_EN defined to enable LSL/LSR/ASR/ROR.
module alu_arm_pipe
    import alu_arm_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    input  logic             in_setf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic             out_err,
    output logic [3:0]       flags_q
);

    logic             accept;
    logic [WIDTH-1:0] coreResult;
    alu_flags_t       coreFlags;
    logic             coreErr;

    logic             valid_q,     valid_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic [3:0]       outFlags_q,  outFlags_d;
    logic             err_q,       err_d;
    logic [3:0]       archFlags_q, archFlags_d;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    alu_arm_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a_i      (in_a),
        .b_i      (in_b),
        .op_i     (in_op),
        .cin_i    (archFlags_q[FLAG_C]),
        .flags_i  (alu_flags_t'(archFlags_q)),
        .result_o (coreResult),
        .nzcv_o   (coreFlags),
        .err_o    (coreErr)
    );

    // A new accept overwrites the output register even while it is being consumed;
    // a consume alone only drops valid and leaves the stale data in place.
    always_comb begin
        valid_d     = valid_q;
        result_d    = result_q;
        outFlags_d  = outFlags_q;
        err_d       = err_q;
        archFlags_d = archFlags_q;
        if (accept) begin
            valid_d    = 1'b1;
            result_d   = coreResult;
            outFlags_d = coreFlags;
            err_d      = coreErr;
            if (in_setf && !coreErr) begin
                archFlags_d = coreFlags;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            outFlags_q  <= '0;
            err_q       <= 1'b0;
            archFlags_q <= '0;
        end else begin
            valid_q     <= valid_d;
            result_q    <= result_d;
            outFlags_q  <= outFlags_d;
            err_q       <= err_d;
            archFlags_q <= archFlags_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_flags  = outFlags_q;
    assign out_err    = err_q;
    assign flags_q    = archFlags_q;

endmodule
